digit_entry_buffer: RTL and testbench

DIGIT_ENTRY_BUFFER -- requirements
Module: digit_entry_buffer

---
 rtl/digit_pkg.sv | 28 ++
 rtl/bcd_to_bin.sv | 38 +++
 rtl/digit_entry_buffer.sv | 137 +++++++++++++
 tb/tb_digit_entry_buffer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/digit_pkg.sv
// digit_pkg -- shared definitions for the digit entry buffer.
//   DIG_W      : width of one key code / display slot
//   DIG_BLANK  : display code for an empty slot
//   DIG_MAX    : largest key code treated as a decimal digit
//   key_code_t : key code type
//   action_t   : one decoded action per cycle after strobe priority
//   is_digit() : true for key codes 0..9
package digit_pkg;

  localparam int          DIG_W     = 5;
  localparam logic [4:0]  DIG_BLANK = 5'd16;
  localparam logic [4:0]  DIG_MAX   = 5'd9;

  typedef logic [DIG_W-1:0] key_code_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CLEAR,
    ACT_COMMIT,
    ACT_BACK,
    ACT_DIGIT
  } action_t;

  function automatic logic is_digit(input key_code_t k);
    return (k <= DIG_MAX);
  endfunction

endpackage

// File: rtl/bcd_to_bin.sv
// bcd_to_bin -- combinational decimal-slot to binary converter.
//   digits   in  DIG_W*NDIG  slot 0 = units; non-digit codes (blank) count as 0
//   value    out VW          binary value, clamped to 2^VW-1
//   overflow out 1           high when the decimal value exceeds 2^VW-1
module bcd_to_bin
  import digit_pkg::*;
#(
  parameter int NDIG = 3,
  parameter int VW   = 8
) (
  input  logic [DIG_W*NDIG-1:0] digits,
  output logic [VW-1:0]         value,
  output logic                  overflow
);

  // Accumulator is always wider than VW so the overflow compare is exact;
  // 17 bits comfortably hold 9999.
  localparam int AW = (VW > 16) ? VW + 1 : 17;
  localparam logic [AW-1:0] MAXV = {{(AW-VW){1'b0}}, {VW{1'b1}}};

  logic [AW-1:0] acc;
  key_code_t     d;

  // Horner evaluation from the most significant slot down: acc = acc*10 + d.
  always_comb begin
    acc = '0;
    d   = '0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      d = digits[k*DIG_W +: DIG_W];
      if (!is_digit(d)) d = '0;
      acc = (acc << 3) + (acc << 1) + AW'(d);
    end
  end

  assign overflow = (acc > MAXV);
  assign value    = overflow ? {VW{1'b1}} : acc[VW-1:0];

endmodule

// File: rtl/digit_entry_buffer.sv
// digit_entry_buffer -- keypad digit entry for NCH colour channels.
// Digits shift in at the units slot; enter converts the held digits to
// binary and commits them to the current channel, then advances the channel.
// Optional feature macro: DIGIT_BACKSPACE_EN (backspace deletes newest digit).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   digito, cambio_digito key code and its one-cycle qualifier
//   enter, clear          commit / discard strobes
//   backspace             delete-newest strobe (ignored unless enabled)
//   digits                entry display, slot 0 = units, blank = 5'd16
//   count, entry_full     number of held digits, count == NDIG
//   ch_sel                channel currently being edited
//   ch_value              committed values, channel i at [i*VW +: VW]
//   frame_valid           one-cycle pulse after the last channel commits
//   sat                   last commit saturated (held until next commit)
// Strobe priority in one cycle: clear > enter > backspace > digit; a
// winning strobe drops all lower ones even when it itself has no effect.
module digit_entry_buffer
  import digit_pkg::*;
#(
  parameter int NDIG = 3,
  parameter int NCH  = 3,
  parameter int VW   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            digito,
  input  logic                  cambio_digito,
  input  logic                  enter,
  input  logic                  clear,
  input  logic                  backspace,
  output logic [5*NDIG-1:0]     digits,
  output logic [2:0]            count,
  output logic                  entry_full,
  output logic [1:0]            ch_sel,
  output logic [VW*NCH-1:0]     ch_value,
  output logic                  frame_valid,
  output logic                  sat
);

  localparam logic [2:0] COUNT_MAX = 3'(NDIG);
  localparam logic [1:0] CH_LAST   = 2'(NCH - 1);

  logic [DIG_W*NDIG-1:0] slots_q;
  logic [2:0]            count_q;
  logic [1:0]            ch_sel_q;
  logic [VW*NCH-1:0]     ch_val_q;
  logic                  fv_q;
  logic                  sat_q;

  logic [VW-1:0]         conv_value;
  logic                  conv_ovf;
  action_t               act;

  bcd_to_bin #(.NDIG(NDIG), .VW(VW)) u_conv (
    .digits   (slots_q),
    .value    (conv_value),
    .overflow (conv_ovf)
  );

  // Priority decode of the strobes into a single action.
  always_comb begin
    act = ACT_NONE;
    if (clear) begin
      act = ACT_CLEAR;
    end else if (enter) begin
      act = (count_q != 3'd0) ? ACT_COMMIT : ACT_NONE;
    end
`ifdef DIGIT_BACKSPACE_EN
    else if (backspace) begin
      act = (count_q != 3'd0) ? ACT_BACK : ACT_NONE;
    end
`endif
    else if (cambio_digito && is_digit(digito) && (count_q != COUNT_MAX)) begin
      act = ACT_DIGIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q  <= {NDIG{DIG_BLANK}};
      count_q  <= 3'd0;
      ch_sel_q <= 2'd0;
      ch_val_q <= '0;
      fv_q     <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      fv_q <= 1'b0;
      case (act)
        ACT_CLEAR: begin
          slots_q <= {NDIG{DIG_BLANK}};
          count_q <= 3'd0;
        end
        ACT_COMMIT: begin
          for (int i = 0; i < NCH; i++) begin
            if (ch_sel_q == 2'(i)) ch_val_q[i*VW +: VW] <= conv_value;
          end
          sat_q   <= conv_ovf;
          slots_q <= {NDIG{DIG_BLANK}};
          count_q <= 3'd0;
          if (ch_sel_q == CH_LAST) begin
            ch_sel_q <= 2'd0;
            fv_q     <= 1'b1;
          end else begin
            ch_sel_q <= ch_sel_q + 2'd1;
          end
        end
`ifdef DIGIT_BACKSPACE_EN
        ACT_BACK: begin
          for (int k = 0; k < NDIG - 1; k++) begin
            slots_q[k*DIG_W +: DIG_W] <= slots_q[(k+1)*DIG_W +: DIG_W];
          end
          slots_q[(NDIG-1)*DIG_W +: DIG_W] <= DIG_BLANK;
          count_q <= count_q - 3'd1;
        end
`endif
        ACT_DIGIT: begin
          for (int k = 1; k < NDIG; k++) begin
            slots_q[k*DIG_W +: DIG_W] <= slots_q[(k-1)*DIG_W +: DIG_W];
          end
          slots_q[DIG_W-1:0] <= digito;
          count_q <= count_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign digits      = slots_q;
  assign count       = count_q;
  assign entry_full  = (count_q == COUNT_MAX);
  assign ch_sel      = ch_sel_q;
  assign ch_value    = ch_val_q;
  assign frame_valid = fv_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_digit_entry_buffer.sv
// tb_digit_entry_buffer -- directed bench for digit_entry_buffer (defaults
// NDIG=3, NCH=3, VW=8). Each driven operation pushes a hand-computed expected
// snapshot of all outputs; a monitor pops and compares on the falling edge.
module tb_digit_entry_buffer;

  localparam int NDIG = 3;
  localparam int NCH  = 3;
  localparam int VW   = 8;
  // snapshot = {digits[15], count[3], full[1], ch_sel[2], ch_value[24], fv[1], sat[1]}
  localparam int W = 15 + 3 + 1 + 2 + 24 + 1 + 1;
  localparam logic [4:0] B = 5'd16;

  logic                  clk;
  logic                  rst_n;
  logic [4:0]            digito;
  logic                  cambio_digito;
  logic                  enter;
  logic                  clear;
  logic                  backspace;
  logic [5*NDIG-1:0]     digits;
  logic [2:0]            count;
  logic                  entry_full;
  logic [1:0]            ch_sel;
  logic [VW*NCH-1:0]     ch_value;
  logic                  frame_valid;
  logic                  sat;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  digit_entry_buffer #(.NDIG(NDIG), .NCH(NCH), .VW(VW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .digito        (digito),
    .cambio_digito (cambio_digito),
    .enter         (enter),
    .clear         (clear),
    .backspace     (backspace),
    .digits        (digits),
    .count         (count),
    .entry_full    (entry_full),
    .ch_sel        (ch_sel),
    .ch_value      (ch_value),
    .frame_valid   (frame_valid),
    .sat           (sat)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [14:0] dg(input logic [4:0] s2, s1, s0);
    return {s2, s1, s0};
  endfunction

  task automatic expect_state(input string nm, input logic [14:0] e_dig,
                              input logic [2:0] e_cnt, input logic [1:0] e_sel,
                              input logic [23:0] e_chv, input logic e_fv,
                              input logic e_sat);
    logic e_full;
    e_full = (e_cnt == 3'd3);
    exp_q.push_back({e_dig, e_cnt, e_full, e_sel, e_chv, e_fv, e_sat});
    name_q.push_back(nm);
  endtask

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic strobe(input logic [4:0] d, input logic cd, input logic en,
                        input logic cl, input logic bs);
    @(posedge clk); #1;
    digito = d; cambio_digito = cd; enter = en; clear = cl; backspace = bs;
    @(posedge clk); #1;
    digito = 5'd0; cambio_digito = 1'b0; enter = 1'b0; clear = 1'b0; backspace = 1'b0;
  endtask

  task automatic key(input logic [4:0] d);
    strobe(d, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    string        nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        cmp(nm, "digits",      32'(digits),      32'(e[46:32]));
        cmp(nm, "count",       32'(count),       32'(e[31:29]));
        cmp(nm, "entry_full",  32'(entry_full),  32'(e[28]));
        cmp(nm, "ch_sel",      32'(ch_sel),      32'(e[27:26]));
        cmp(nm, "ch_value",    32'(ch_value),    32'(e[25:2]));
        cmp(nm, "frame_valid", 32'(frame_valid), 32'(e[1]));
        cmp(nm, "sat",         32'(sat),         32'(e[0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    digito = 5'd0; cambio_digito = 1'b0; enter = 1'b0; clear = 1'b0; backspace = 1'b0;
    #1;
    expect_state("reset", dg(B,B,B), 3'd0, 2'd0, 24'h000000, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1,2,8 then enter -> channel 0 = 128
    key(5'd1);  expect_state("d1",      dg(B,B,1), 3'd1, 2'd0, 24'h000000, 1'b0, 1'b0);
    key(5'd2);  expect_state("d12",     dg(B,1,2), 3'd2, 2'd0, 24'h000000, 1'b0, 1'b0);
    key(5'd8);  expect_state("d128",    dg(1,2,8), 3'd3, 2'd0, 24'h000000, 1'b0, 1'b0);
    key(5'd4);  expect_state("full_ign",dg(1,2,8), 3'd3, 2'd0, 24'h000000, 1'b0, 1'b0);
    strobe(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_state("commit0", dg(B,B,B), 3'd0, 2'd1, 24'h000080, 1'b0, 1'b0);

    // enter with nothing held, non-digit key code
    strobe(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_state("enter_empty", dg(B,B,B), 3'd0, 2'd1, 24'h000080, 1'b0, 1'b0);
    key(5'd12); expect_state("code_ign", dg(B,B,B), 3'd0, 2'd1, 24'h000080, 1'b0, 1'b0);

    // 9,9,9 on channel 1 -> saturate to 255
    key(5'd9);  expect_state("d9",   dg(B,B,9), 3'd1, 2'd1, 24'h000080, 1'b0, 1'b0);
    key(5'd9);  expect_state("d99",  dg(B,9,9), 3'd2, 2'd1, 24'h000080, 1'b0, 1'b0);
    key(5'd9);  expect_state("d999", dg(9,9,9), 3'd3, 2'd1, 24'h000080, 1'b0, 1'b0);
    strobe(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_state("commit1_sat", dg(B,B,B), 3'd0, 2'd2, 24'h00FF80, 1'b0, 1'b1);

    // channel 2: digit 5, then enter together with digit 7 -> commit only
    key(5'd5);  expect_state("d5", dg(B,B,5), 3'd1, 2'd2, 24'h00FF80, 1'b0, 1'b1);
    strobe(5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_state("commit2_frame", dg(B,B,B), 3'd0, 2'd0, 24'h05FF80, 1'b1, 1'b0);
    idle_cycle();
    expect_state("frame_end", dg(B,B,B), 3'd0, 2'd0, 24'h05FF80, 1'b0, 1'b0);

    // clear beats enter
    key(5'd3);  expect_state("d3", dg(B,B,3), 3'd1, 2'd0, 24'h05FF80, 1'b0, 1'b0);
    strobe(5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_state("clear_enter", dg(B,B,B), 3'd0, 2'd0, 24'h05FF80, 1'b0, 1'b0);

    // backspace
    key(5'd4);  expect_state("d4",  dg(B,B,4), 3'd1, 2'd0, 24'h05FF80, 1'b0, 1'b0);
    key(5'd5);  expect_state("d45", dg(B,4,5), 3'd2, 2'd0, 24'h05FF80, 1'b0, 1'b0);
    strobe(5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef DIGIT_BACKSPACE_EN
    expect_state("backspace", dg(B,B,4), 3'd1, 2'd0, 24'h05FF80, 1'b0, 1'b0);
`else
    expect_state("backspace_ign", dg(B,4,5), 3'd2, 2'd0, 24'h05FF80, 1'b0, 1'b0);
`endif

    // 6 on channel 0 -> channel 0 becomes 6, other channels retained
    strobe(5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_state("clear", dg(B,B,B), 3'd0, 2'd0, 24'h05FF80, 1'b0, 1'b0);
    key(5'd6);  expect_state("d6", dg(B,B,6), 3'd1, 2'd0, 24'h05FF80, 1'b0, 1'b0);
    strobe(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_state("recommit0", dg(B,B,B), 3'd0, 2'd1, 24'h05FF06, 1'b0, 1'b0);

    // asynchronous reset mid-entry, asserted away from any clock edge
    key(5'd7);  expect_state("d7", dg(B,B,7), 3'd1, 2'd1, 24'h05FF06, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    expect_state("rst_mid", dg(B,B,B), 3'd0, 2'd0, 24'h000000, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    key(5'd2);  expect_state("after_rst", dg(B,B,2), 3'd1, 2'd0, 24'h000000, 1'b0, 1'b0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
